// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int                  RELOCK_W   = 8;
  localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

  function automatic logic [RELOCK_W-1:0] relock_inc(input logic [RELOCK_W-1:0] c);
    return (c == RELOCK_MAX) ? c : c + RELOCK_W'(1);
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Single-bit synchroniser: SYNC_STAGES flops, synchronous reset to 0.
module pll_sup_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk_sys) begin
    if (reset) ff <= '0;
    else       ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses pll_rst, qualifies lock, releases core_reset.
// Define PLL_SUPERVISOR_TIMEOUT_EN to compile in the WAIT_LOCK watchdog.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 1048576,
  parameter int CNT_W        = 21
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                locked,
  input  logic                clr_status,
  output logic                pll_rst,
  output logic                core_reset,
  output logic                ready,
  output logic                lost_lock,
  output logic [RELOCK_W-1:0] relock_cnt
);

  // Elaboration-time sanity checks on the configuration.
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
  if (LOCK_TIMEOUT > 2**CNT_W) begin : g_bad_to_w
    $error("CNT_W too narrow for LOCK_TIMEOUT");
  end
`endif
  if (SYNC_STAGES < 2 || RST_HOLD < 1 || LOCK_STABLE < 1 || LOCK_TIMEOUT < 1 ||
      RST_HOLD > 2**CNT_W || LOCK_STABLE > 2**CNT_W) begin : g_bad_cfg
    $error("pll_lock_supervisor: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
`endif

  logic             locked_s;
  pll_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             run_loss;

  pll_sup_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (locked),
    .q       (locked_s)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    run_loss  = 1'b0;
    unique case (state)
      PLL_RST: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end
`ifdef PLL_SUPERVISOR_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          state_nxt = PLL_RST;
          cnt_nxt   = '0;
        end
`else
        else cnt_nxt = '0;  // no watchdog: keep the counter parked
`endif
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = '0;
        if (!locked_s) begin
          state_nxt = PLL_RST;
          run_loss  = 1'b1;
        end
      end
      default: begin
        state_nxt = PLL_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= PLL_RST;
      cnt        <= '0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pll_rst    <= (state_nxt == PLL_RST);
      core_reset <= (state_nxt != RUN);
      ready      <= (state_nxt == RUN);
    end
  end

  // A clear coinciding with a loss wipes history first, then records the loss.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lost_lock  <= 1'b0;
      relock_cnt <= '0;
    end else if (run_loss) begin
      lost_lock  <= 1'b1;
      relock_cnt <= relock_inc(clr_status ? '0 : relock_cnt);
    end else if (clr_status) begin
      lost_lock  <= 1'b0;
      relock_cnt <= '0;
    end
  end

endmodule
